// File: rtl/fpga_apb_pkg.sv
// Shared types for the FPGA-side APB4 initiator and its command sources.
package fpga_apb_pkg;

    localparam int APB_STRB_WIDTH = 4;
    localparam int APB_PROT_WIDTH = 3;
    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_init_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
        logic [APB_PROT_WIDTH-1:0] prot;
    } apb_init_req_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      slverr;
        logic                      timeout;
    } apb_init_rsp_t;

endpackage

// File: rtl/fpga_apb_initiator.sv
// APB4 requester: one transfer per valid/ready command, with response
// carrying read data, slave error and ACCESS-phase timeout status.
module fpga_apb_initiator
    import fpga_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      core_clk,
    input  logic                      core_rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [APB_STRB_WIDTH-1:0] req_strb,
    input  logic [APB_PROT_WIDTH-1:0] req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic [15:0]               err_count,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [APB_STRB_WIDTH-1:0] PSTRB,
    output logic [APB_PROT_WIDTH-1:0] PPROT,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // Counter is kept at least one bit wide so a disabled timeout still elaborates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_init_state_e           state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [APB_STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [APB_PROT_WIDTH-1:0] pprot_q, pprot_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_slverr_q, rsp_slverr_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [15:0]               err_count_q, err_count_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_inc;

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        paddr_d       = paddr_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        err_inc       = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    pprot_d     = req_prot;
                    pwdata_d    = req_write ? req_wdata : '0;
                    pstrb_d     = req_write ? req_strb : '0;
                    psel_d      = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout expiring in the same cycle.
                if (PREADY) begin
                    rsp_rdata_d   = (pwrite_q || PSLVERR) ? '0 : PRDATA;
                    rsp_slverr_d  = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    err_inc       = PSLVERR;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    err_inc       = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_count_d = err_count_q;
        if (err_inc && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            paddr_q       <= paddr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_count_q   <= err_count_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_count   = err_count_q;
    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;

endmodule

// File: tb/tb_fpga_apb_initiator.sv
// Directed self-checking bench for fpga_apb_initiator (TIMEOUT_CYCLES = 8).
module tb_fpga_apb_initiator;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [15:0] err_count;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    fpga_apb_initiator #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .err_count(err_count),
        .PADDR(PADDR),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PSTRB(PSTRB),
        .PPROT(PPROT),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 core_clk = ~core_clk;

    // Present one command starting at a negedge; returns just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
        req_valid = 1'b1;
        @(posedge core_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge core_clk);
        #1 rsp_ready = 1'b0;
        @(negedge core_clk);
    endtask

    task automatic test_reset();
        #1 core_rst = 1'b1;
        #2;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0001", {PSEL, PENABLE, rsp_valid, req_ready});
        end
        n_checks++;
        if ({PADDR, PWDATA, PSTRB, PPROT, PWRITE} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_apb: got %h want 0", {PADDR, PWDATA, PSTRB, PPROT, PWRITE});
        end
        n_checks++;
        if ({rsp_rdata, rsp_slverr, rsp_timeout, err_count} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h want 0", {rsp_rdata, rsp_slverr, rsp_timeout, err_count});
        end
        @(negedge core_clk);
        @(negedge core_clk);
        core_rst = 1'b0;
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 01", {PSEL, req_ready});
        end
    endtask

    task automatic test_zero_wait_read();
        PREADY = 1'b1;
        PRDATA = 32'hDEADBEEF;
        PSLVERR = 1'b0;
        issue(1'b0, 32'h3003_0000, 32'hFFFF_FFFF, 4'hF, 3'b000);
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL zw_setup_ctrl: got %b want 1000", {PSEL, PENABLE, rsp_valid, req_ready});
        end
        n_checks++;
        if (PADDR !== 32'h3003_0000 || PWRITE !== 1'b0 || PSTRB !== 4'h0 || PWDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL zw_setup_bus: addr %h wr %b strb %h wdata %h want 30030000 0 0 0",
                     PADDR, PWRITE, PSTRB, PWDATA);
        end
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, PSTRB} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL zw_access: got %b want 1100000", {PSEL, PENABLE, rsp_valid, PSTRB});
        end
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_slverr, rsp_timeout, PSTRB} !== 9'b001000000) begin
            n_fail++;
            $display("FAIL zw_resp_ctrl: got %b want 001000000",
                     {PSEL, PENABLE, rsp_valid, rsp_slverr, rsp_timeout, PSTRB});
        end
        n_checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL zw_rdata: got %h want deadbeef", rsp_rdata);
        end
        ack_rsp();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL zw_ack: got %b want 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_wait_write();
        int bad = 0;
        PREADY = 1'b0;
        PRDATA = 32'hCAFEF00D;
        issue(1'b1, 32'h10, 32'h12345678, 4'hF, 3'b010);
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin
            n_fail++;
            $display("FAIL ww_setup: got %b want 101", {PSEL, PENABLE, PWRITE});
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge core_clk);
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 32'h10 ||
                PWDATA !== 32'h12345678 || PSTRB !== 4'hF || PPROT !== 3'b010) begin
                bad++;
            end
            if (i == 6) PREADY = 1'b1;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL ww_access_stable: got %0d unstable cycles want 0", bad);
        end
        @(negedge core_clk);
        PREADY = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_slverr, rsp_timeout} !== 5'b00100 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ww_resp: ctrl %b rdata %h want 00100 0",
                     {PSEL, PENABLE, rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
        end
        ack_rsp();
    endtask

    task automatic test_slave_error();
        n_checks++;
        if (err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL se_cnt_before: got %0d want 0", err_count);
        end
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        PRDATA = 32'hAAAA5555;
        issue(1'b0, 32'h20, 32'h99999999, 4'h3, 3'b001);
        @(negedge core_clk);
        n_checks++;
        if (PWDATA !== 32'h0 || PSTRB !== 4'h0) begin
            n_fail++;
            $display("FAIL se_read_forced: wdata %h strb %h want 0 0", PWDATA, PSTRB);
        end
        @(negedge core_clk);
        @(negedge core_clk);
        PSLVERR = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL se_resp: ctrl %b rdata %h want 110 0",
                     {rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
        end
        n_checks++;
        if (err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL se_cnt_after: got %0d want 1", err_count);
        end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int bad = 0;
        PREADY = 1'b0;
        issue(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
        @(negedge core_clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge core_clk);
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL to_access: got %0d bad cycles want 0", bad);
        end
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_slverr, rsp_timeout} !== 5'b00111 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL to_abort: ctrl %b rdata %h want 00111 0",
                     {PSEL, PENABLE, rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
        end
        n_checks++;
        if (err_count !== 16'd2) begin
            n_fail++;
            $display("FAIL to_cnt: got %0d want 2", err_count);
        end
        ack_rsp();
        bad = 0;
        PRDATA = 32'h0BADC0DE;
        issue(1'b0, 32'h44, 32'h0, 4'h0, 3'b000);
        @(negedge core_clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge core_clk);
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110) bad++;
            if (i == 8) PREADY = 1'b1;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL to_edge_access: got %0d bad cycles want 0", bad);
        end
        @(negedge core_clk);
        PREADY = 1'b0;
        n_checks++;
        if ({PSEL, rsp_valid, rsp_slverr, rsp_timeout} !== 4'b0100 || rsp_rdata !== 32'h0BADC0DE) begin
            n_fail++;
            $display("FAIL to_edge_resp: ctrl %b rdata %h want 0100 0badc0de",
                     {PSEL, rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
        end
        n_checks++;
        if (err_count !== 16'd2) begin
            n_fail++;
            $display("FAIL to_edge_cnt: got %0d want 2", err_count);
        end
        ack_rsp();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        PREADY = 1'b1;
        PRDATA = 32'h5A5A1234;
        issue(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
        @(negedge core_clk);
        @(negedge core_clk);
        @(negedge core_clk);
        req_write = 1'b0;
        req_addr  = 32'h60;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ({rsp_valid, rsp_slverr, rsp_timeout, req_ready, PSEL} !== 5'b10000 ||
                rsp_rdata !== 32'h5A5A1234) begin
                bad++;
            end
            @(negedge core_clk);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        rsp_ready = 1'b1;
        @(posedge core_clk);
        #1 rsp_ready = 1'b0;
        @(negedge core_clk);
        n_checks++;
        if ({rsp_valid, req_ready, PSEL} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_release: got %b want 010", {rsp_valid, req_ready, PSEL});
        end
        @(posedge core_clk);
        #1 req_valid = 1'b0;
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, req_ready} !== 3'b100 || PADDR !== 32'h60) begin
            n_fail++;
            $display("FAIL bp_next_accept: ctrl %b addr %h want 100 60", {PSEL, PENABLE, req_ready}, PADDR);
        end
        @(negedge core_clk);
        @(negedge core_clk);
        PREADY = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5A1234) begin
            n_fail++;
            $display("FAIL bp_next_resp: valid %b rdata %h want 1 5a5a1234", rsp_valid, rsp_rdata);
        end
        ack_rsp();
    endtask

    task automatic test_async_reset();
        PREADY = 1'b0;
        issue(1'b1, 32'h70, 32'h11112222, 4'h6, 3'b100);
        @(negedge core_clk);
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            n_fail++;
            $display("FAIL ar_in_access: got %b want 11", {PSEL, PENABLE});
        end
        #2 core_rst = 1'b1;
        #1;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: ctrl %b cnt %0d want 0001 0",
                     {PSEL, PENABLE, rsp_valid, req_ready}, err_count);
        end
        @(negedge core_clk);
        core_rst = 1'b0;
        @(negedge core_clk);
        @(negedge core_clk);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_after: ctrl %b cnt %0d want 0001 0",
                     {PSEL, PENABLE, rsp_valid, req_ready}, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_slave_error();
        test_timeout();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_apb_initiator.md
Name: fpga_apb_initiator

Overview:
APB4 requester that drives the Caliptra subsystem APB completer from a simple valid/ready command interface. On the FPGA, a host-side command source (realtime register block or test sequencer) issues it single read/write commands. It runs one APB transfer per command and returns a response that carries read data, error and timeout status. It sits in the FPGA wrapper between the command source and the subsystem APB slave port, on core_clk.

Parameters:
ADDR_WIDTH, 32, APB address width (PADDR and req_addr).
DATA_WIDTH, 32, APB data width; must be 32 (one PSTRB bit per byte, 4 bits).
TIMEOUT_CYCLES, 1024, maximum ACCESS-phase cycles waiting for PREADY; 0 disables the timeout.

Ports:
core_clk  in  1  sole clock
core_rst  in  1  reset, asynchronous, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  transfer address
req_wdata  in  DATA_WIDTH  write data
req_strb  in  4  write byte strobes
req_prot  in  3  PPROT value
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes, errors and timeouts)
rsp_slverr  out  1  PSLVERR sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
err_count  out  16  saturating count of error and timeout responses
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  4  APB strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- All outputs are registered. Reset (async, immediate) values: state IDLE, all APB outputs 0, rsp_* 0, err_count 0. req_ready = 1 out of reset.
- FSM has four states: IDLE, SETUP, ACCESS, RESP. One transfer is outstanding at a time.
- IDLE: req_ready=1. On handshake, capture addr/write/prot into PADDR/PWRITE/PPROT. For writes, load wdata/strb into PWDATA/PSTRB; for reads, force PWDATA=0 and PSTRB=0. Set PSEL=1, drop req_ready, go to SETUP.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0. Next: PENABLE=1, go to ACCESS, clear the timeout counter.
- ACCESS: PSEL and PENABLE held at 1; PADDR/PWRITE/PWDATA/PSTRB/PPROT stay stable.
  - If PREADY=1: rsp_rdata = PWRITE ? 0 : PRDATA; rsp_slverr = PSLVERR; rsp_timeout = 0. If PSLVERR=1, force rsp_rdata = 0. Then PSEL=0, PENABLE=0, rsp_valid=1, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and the counter has reached TIMEOUT_CYCLES-1: abort with PSEL=0, PENABLE=0, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, go to RESP.
  - Otherwise, increment the counter. The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.
- Simultaneous PREADY and timeout expiry: PREADY wins; completes normally with no timeout.
- RESP: rsp_valid and rsp_* held stable until rsp_ready. On handshake: rsp_valid=0, req_ready=1, go to IDLE. rsp_ready is ignored outside RESP.
- err_count increments by 1 on entry to RESP when rsp_slverr=1. It saturates at 0xFFFF and is cleared only by reset.
- Latency with zero-wait completer: request handshake at cycle 0; SETUP at cycle 1; ACCESS at cycle 2 with PREADY sampled; rsp_valid at cycle 3. The next request can be accepted at the cycle after the rsp handshake.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously; any pending response is discarded.
- PADDR/PWRITE/PPROT/PWDATA/PSTRB hold their last values in IDLE; only PSEL qualifies them.

Decomposition:
- Shared package fpga_apb_pkg holds: state enum apb_init_state_e {IDLE, SETUP, ACCESS, RESP}, APB_STRB_WIDTH=4, APB_PROT_WIDTH=3, and the request/response struct typedefs used by the command source.
- No sub-module. The timeout counter and FSM stay in one file.

Test Plan:
- Zero-wait read: req read addr 0x30030000; completer returns PRDATA=0xDEADBEEF with PREADY at the first ACCESS cycle -> PSEL at cycle 1, PENABLE at cycle 2, rsp_valid at cycle 3 with rdata=0xDEADBEEF, slverr=0, timeout=0, and PSTRB=0 throughout.
- Wait-state write: req write addr 0x10, wdata 0x12345678, strb 0xF; PREADY delayed 5 cycles -> PSEL/PENABLE/PADDR/PWDATA stable for all 6 ACCESS cycles; rsp rdata=0, slverr=0.
- Slave error: read with PSLVERR=1 on PREADY -> rsp_slverr=1, rdata=0, err_count goes 0→1.
- Timeout: TIMEOUT_CYCLES=8, PREADY held 0 -> abort after 8 ACCESS cycles; PSEL=0; rsp_timeout=1, slverr=1; err_count increments. Repeat with PREADY=1 on the 8th ACCESS cycle -> normal completion, timeout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 -> rsp fields stable, req_ready=0, no new PSEL. Then rsp_ready=1 -> next request is accepted the following cycle.
- Async reset asserted mid-ACCESS -> PSEL/PENABLE/rsp_valid are 0 in the same cycle; after release req_ready=1 and err_count=0.
